// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: grants the single FIFO write port to one of two producers in
// round-robin bursts of at most MAX_BURST words, and tracks free FIFO slots
// with a credit counter so a write is never issued while the FIFO is full.
//
// Producer handshake (valid/ready): reqx is valid, ackx is ready. A word on
// dinx transfers on a rising edge where reqx && ackx are both high. Until
// then the producer holds reqx/dinx stable. ackx is combinational and is
// never asserted in IDLE or while credits == 0. At most one of ack0/ack1 is
// high in any cycle.
//
// The FSM state is visible on grant: 00 = IDLE, 01 = BURST0, 10 = BURST1.
module fifo_wr_arb #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 4,
    parameter int CW        = 3,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rstp,
    input  logic             req0,
    input  logic [WIDTH-1:0] din0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] din1,
    output logic             ack1,
    input  logic             fifo_rd,
    output logic             fifo_writep,
    output logic [WIDTH-1:0] fifo_din,
    output logic [1:0]       grant,
    output logic [CW-1:0]    credits,
    output logic             err
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    // One-hot encoding so grant is a direct copy of the state.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BURST0 = 2'b01,
        BURST1 = 2'b10
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            prio;       // 0: requester 0 first, 1: requester 1 first
    logic [BW-1:0]   burst_cnt;  // words accepted in the current burst
    logic            has_credit;
    logic            ack;

    assign grant      = state;
    assign has_credit = (credits != '0);
    assign ack        = ack0 | ack1;

    // Next-state and handshake decode.
    always_comb begin
        next_state = state;
        ack0       = 1'b0;
        ack1       = 1'b0;
        case (state)
            IDLE: begin
                if (has_credit) begin
                    if (!prio) begin
                        if (req0)      next_state = BURST0;
                        else if (req1) next_state = BURST1;
                    end else begin
                        if (req1)      next_state = BURST1;
                        else if (req0) next_state = BURST0;
                    end
                end
            end
            BURST0: begin
                if (!req0) begin
                    next_state = IDLE;
                end else if (has_credit) begin
                    ack0 = 1'b1;
                    if (burst_cnt == BW'(MAX_BURST - 1)) next_state = IDLE;
                end
            end
            BURST1: begin
                if (!req1) begin
                    next_state = IDLE;
                end else if (has_credit) begin
                    ack1 = 1'b1;
                    if (burst_cnt == BW'(MAX_BURST - 1)) next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) state <= IDLE;
        else      state <= next_state;
    end

    // Priority hand-over on burst entry; burst length counting.
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            prio      <= 1'b0;
            burst_cnt <= '0;
        end else if (state == IDLE && next_state != IDLE) begin
            prio      <= (next_state == BURST0);
            burst_cnt <= '0;
        end else if (next_state == IDLE) begin
            burst_cnt <= '0;
        end else if (ack) begin
            burst_cnt <= burst_cnt + BW'(1);
        end
    end

    // Registered write strobe and data towards the FIFO.
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            fifo_writep <= 1'b0;
            fifo_din    <= '0;
        end else begin
            fifo_writep <= ack;
            if (ack) fifo_din <= ack0 ? din0 : din1;
        end
    end

    // Credit counter: ack consumes a slot, an accepted read frees one.
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            credits <= CW'(DEPTH);
            err     <= 1'b0;
        end else begin
            case ({ack, fifo_rd})
                2'b10: credits <= credits - CW'(1);
                2'b01: begin
                    if (credits == CW'(DEPTH)) err <= 1'b1;
                    else                       credits <= credits + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed testbench for fifo_wr_arb: round-robin bursts, reset mid-burst,
// single-producer credit exhaustion and stall, credit recovery, simultaneous
// ack/read, early release and over-read error.
module tb_fifo_wr_arb;

    logic        clk;
    logic        rstp;
    logic        req0, req1;
    logic [15:0] din0, din1;
    logic        ack0, ack1;
    logic        fifo_rd;
    logic        fifo_writep;
    logic [15:0] fifo_din;
    logic [1:0]  grant;
    logic [2:0]  credits;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    int n0, n1;

    fifo_wr_arb #(.WIDTH(16), .DEPTH(4), .CW(3), .MAX_BURST(4)) dut (
        .clk(clk), .rstp(rstp),
        .req0(req0), .din0(din0), .ack0(ack0),
        .req1(req1), .din1(din1), .ack1(ack1),
        .fifo_rd(fifo_rd), .fifo_writep(fifo_writep), .fifo_din(fifo_din),
        .grant(grant), .credits(credits), .err(err)
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Round-robin table (both requesters held, consumer reads whenever the
    // FIFO holds a word). Hand-traced per cycle.
    logic [1:0]  rr_grant [0:11] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                                     2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    logic [2:0]  rr_cr    [0:11] = '{3'd4, 3'd4, 3'd3, 3'd3, 3'd3, 3'd3,
                                     3'd4, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
    logic        rr_rd    [0:11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                     1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        rr_wp    [0:11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                     1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] rr_din   [0:11] = '{16'h0000, 16'h0000, 16'hA001, 16'hA002,
                                     16'hA003, 16'hA004, 16'hA004, 16'hB001,
                                     16'hB002, 16'hB003, 16'hB004, 16'hB004};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rstp = 1'b1; req0 = 1'b0; req1 = 1'b0;
        din0 = '0; din1 = '0; fifo_rd = 1'b0;

        // Reset state.
        #7;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_credits", 32'(credits), 32'd4);
        chk("rst_writep", 32'(fifo_writep), 32'd0);
        chk("rst_din", 32'(fifo_din), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_acks", 32'({ack0, ack1}), 32'd0);
        #1 rstp = 1'b0;

        // Round robin: both requesters held.
        n0 = 0; n1 = 0;
        for (int r = 0; r < 12; r++) begin
            tick();
            req0 = 1'b1; req1 = 1'b1;
            fifo_rd = rr_rd[r];
            din0 = 16'hA001 + 16'(n0);
            din1 = 16'hB001 + 16'(n1);
            settle();
            chk($sformatf("rr_grant_c%0d", r), 32'(grant), 32'(rr_grant[r]));
            chk($sformatf("rr_credits_c%0d", r), 32'(credits), 32'(rr_cr[r]));
            chk($sformatf("rr_ack0_c%0d", r), 32'(ack0),
                32'(rr_grant[r] == 2'b01 && rr_cr[r] != 3'd0));
            chk($sformatf("rr_ack1_c%0d", r), 32'(ack1),
                32'(rr_grant[r] == 2'b10 && rr_cr[r] != 3'd0));
            chk($sformatf("rr_writep_c%0d", r), 32'(fifo_writep), 32'(rr_wp[r]));
            chk($sformatf("rr_din_c%0d", r), 32'(fifo_din), 32'(rr_din[r]));
            if (rr_grant[r] == 2'b01 && rr_cr[r] != 3'd0) n0++;
            if (rr_grant[r] == 2'b10 && rr_cr[r] != 3'd0) n1++;
        end
        chk("rr_err", 32'(err), 32'd0);

        // Reset mid-burst, no clock edge in between.
        tick();
        fifo_rd = 1'b0;
        din0 = 16'hA006;
        settle();
        chk("mid_writep_pre", 32'(fifo_writep), 32'd1);
        chk("mid_din_pre", 32'(fifo_din), 32'h0000A005);
        chk("mid_credits_pre", 32'(credits), 32'd3);
        #1 rstp = 1'b1;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_credits", 32'(credits), 32'd4);
        chk("mid_rst_writep", 32'(fifo_writep), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_ack0", 32'(ack0), 32'd0);
        req0 = 1'b0; req1 = 1'b0;
        #1 rstp = 1'b0;

        // Single producer, no reads: four writes, credits run out.
        tick();
        req0 = 1'b1; din0 = 16'h0001;
        settle();
        chk("sp_idle_grant", 32'(grant), 32'd0);
        chk("sp_idle_ack0", 32'(ack0), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            din0 = 16'(k);
            settle();
            chk($sformatf("sp_grant_w%0d", k), 32'(grant), 32'd1);
            chk($sformatf("sp_ack0_w%0d", k), 32'(ack0), 32'd1);
            chk($sformatf("sp_credits_w%0d", k), 32'(credits), 32'(5 - k));
            chk($sformatf("sp_writep_w%0d", k), 32'(fifo_writep), 32'(k > 1));
            if (k > 1) chk($sformatf("sp_din_w%0d", k), 32'(fifo_din), 32'(k - 1));
        end
        tick();
        din0 = 16'h0005;
        settle();
        chk("sp_last_writep", 32'(fifo_writep), 32'd1);
        chk("sp_last_din", 32'(fifo_din), 32'd4);
        chk("sp_last_credits", 32'(credits), 32'd0);
        chk("sp_last_grant", 32'(grant), 32'd0);
        chk("sp_last_ack0", 32'(ack0), 32'd0);
        tick();
        fifo_rd = 1'b1;
        settle();
        chk("sp_hold_writep", 32'(fifo_writep), 32'd0);
        chk("sp_hold_din", 32'(fifo_din), 32'd4);
        chk("sp_hold_grant", 32'(grant), 32'd0);
        tick();
        fifo_rd = 1'b0;
        settle();
        chk("sp_rd_credits", 32'(credits), 32'd1);
        chk("sp_rd_grant", 32'(grant), 32'd0);
        tick();
        settle();
        chk("sp_regrant", 32'(grant), 32'd1);
        chk("sp_regrant_ack0", 32'(ack0), 32'd1);
        tick();
        din0 = 16'h0006;
        settle();
        chk("stall_grant", 32'(grant), 32'd1);
        chk("stall_ack0", 32'(ack0), 32'd0);
        chk("stall_credits", 32'(credits), 32'd0);
        chk("stall_din", 32'(fifo_din), 32'd5);
        tick();
        settle();
        chk("stall2_grant", 32'(grant), 32'd1);
        chk("stall2_ack0", 32'(ack0), 32'd0);
        chk("stall2_writep", 32'(fifo_writep), 32'd0);
        req0 = 1'b0; req1 = 1'b1; din1 = 16'h00C1;

        // Credit recovery while stalled in BURST1.
        tick();
        fifo_rd = 1'b1;
        settle();
        chk("cr_release_grant", 32'(grant), 32'd0);
        tick();
        fifo_rd = 1'b0;
        settle();
        chk("cr_idle_credits", 32'(credits), 32'd1);
        tick();
        settle();
        chk("cr_b1_grant", 32'(grant), 32'd2);
        chk("cr_b1_ack1", 32'(ack1), 32'd1);
        tick();
        din1 = 16'h00C2; fifo_rd = 1'b1;
        settle();
        chk("cr_stall_grant", 32'(grant), 32'd2);
        chk("cr_stall_ack1", 32'(ack1), 32'd0);
        chk("cr_stall_credits", 32'(credits), 32'd0);
        chk("cr_stall_din", 32'(fifo_din), 32'h000000C1);
        tick();
        fifo_rd = 1'b0;
        settle();
        chk("cr_recover_credits", 32'(credits), 32'd1);
        chk("cr_recover_ack1", 32'(ack1), 32'd1);
        chk("cr_recover_grant", 32'(grant), 32'd2);
        tick();
        din1 = 16'h00C3; req1 = 1'b0; fifo_rd = 1'b1;
        settle();
        chk("cr_back0_credits", 32'(credits), 32'd0);
        chk("cr_back0_writep", 32'(fifo_writep), 32'd1);
        chk("cr_back0_din", 32'(fifo_din), 32'h000000C2);

        // Simultaneous ack and read at credits == 2.
        tick();
        fifo_rd = 1'b1;
        settle();
        chk("sim_pre_credits", 32'(credits), 32'd1);
        tick();
        fifo_rd = 1'b0; req1 = 1'b1;
        settle();
        chk("sim_build_credits", 32'(credits), 32'd2);
        tick();
        fifo_rd = 1'b1;
        settle();
        chk("sim_ack1", 32'(ack1), 32'd1);
        chk("sim_credits_before", 32'(credits), 32'd2);
        tick();
        fifo_rd = 1'b0; req1 = 1'b0;
        settle();
        chk("sim_credits_after", 32'(credits), 32'd2);
        chk("sim_writep", 32'(fifo_writep), 32'd1);
        chk("sim_din", 32'(fifo_din), 32'h000000C3);
        chk("sim_err", 32'(err), 32'd0);

        // Early release after two words; priority already on requester 1.
        rstp = 1'b1;
        #1 rstp = 1'b0;
        tick();
        req0 = 1'b1; din0 = 16'h0011;
        settle();
        tick();
        settle();
        chk("er_ack_w1", 32'(ack0), 32'd1);
        tick();
        din0 = 16'h0012;
        settle();
        chk("er_ack_w2", 32'(ack0), 32'd1);
        tick();
        req0 = 1'b0;
        settle();
        chk("er_drop_grant", 32'(grant), 32'd1);
        chk("er_drop_ack0", 32'(ack0), 32'd0);
        chk("er_drop_credits", 32'(credits), 32'd2);
        chk("er_drop_din", 32'(fifo_din), 32'h00000012);
        tick();
        req0 = 1'b1; req1 = 1'b1; din0 = 16'h0013; din1 = 16'h0021;
        settle();
        chk("er_idle_grant", 32'(grant), 32'd0);
        tick();
        settle();
        chk("er_prio_grant", 32'(grant), 32'd2);
        chk("er_prio_ack1", 32'(ack1), 32'd1);
        chk("er_prio_ack0", 32'(ack0), 32'd0);

        // Over-read at full credits sets sticky err.
        req0 = 1'b0; req1 = 1'b0;
        rstp = 1'b1;
        #1 rstp = 1'b0;
        tick();
        fifo_rd = 1'b1;
        settle();
        chk("or_pre_err", 32'(err), 32'd0);
        tick();
        fifo_rd = 1'b0;
        settle();
        chk("or_credits", 32'(credits), 32'd4);
        chk("or_err", 32'(err), 32'd1);
        tick();
        tick();
        tick();
        settle();
        chk("or_err_sticky", 32'(err), 32'd1);
        chk("or_credits_sticky", 32'(credits), 32'd4);
        rstp = 1'b1;
        #1;
        chk("or_err_cleared", 32'(err), 32'd0);
        rstp = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
